// File: rtl/multiword_adder_seq.sv
// Serial multi-precision adder/subtractor: 16-bit words stream LS-first through one
// prefix adder, with a registered carry chaining the words of an operation.

module prefix_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  // Kogge-Stone group generate/propagate; carry-in folds in after the tree.
  function automatic logic [16:0] prefix_sum(input logic [15:0] x, input logic [15:0] y,
                                             input logic ci);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] gn;
    logic [15:0] pn;
    logic [15:0] p0;
    logic [16:0] c;
    g  = x & y;
    p  = x ^ y;
    p0 = p;
    for (int d = 1; d < 16; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < 16; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    c[0] = ci;
    for (int i = 0; i < 16; i++) begin
      c[i+1] = g[i] | (p[i] & ci);
    end
    return {c[16], p0 ^ c[15:0]};
  endfunction

  assign {cout, s} = prefix_sum(a, b, cin);

endmodule

module multiword_adder_seq #(
  parameter  int MAX_WORDS = 4,
  localparam int IW        = $clog2(MAX_WORDS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_a,
  input  logic [15:0]   in_b,
  input  logic          in_first,
  input  logic          in_last,
  input  logic          in_sub,
  input  logic          in_cin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_s,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          out_cout,
  output logic          out_ovf,
  output logic          out_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [IW-1:0] MAX_IDX = IW'(MAX_WORDS);

  state_t        state_r;
  state_t        state_next_s;
  logic          carry_r;
  logic          sub_r;
  logic [IW-1:0] idx_r;

  logic          accept_s;
  logic          first_s;
  logic          sub_s;
  logic          cin_s;
  logic [15:0]   b_s;
  logic [IW-1:0] idx_s;
  logic          err_s;
  logic          ovf_s;
  logic [15:0]   sum_s;
  logic          cout_s;

  // Single output register: a drain and an accept may happen in the same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept_s = in_valid && in_ready;

  prefix_adder_16bit u_adder (
    .a    (in_a),
    .b    (b_s),
    .cin  (cin_s),
    .s    (sum_s),
    .cout (cout_s)
  );

  // Per-beat operand selection, word index and error tagging.
  always_comb begin
    first_s = in_first || (state_r == IDLE);
    sub_s   = first_s ? in_sub : sub_r;
    cin_s   = first_s ? (in_sub | in_cin) : carry_r;
    b_s     = sub_s ? ~in_b : in_b;
    if (first_s) begin
      idx_s = '0;
    end else if (idx_r >= MAX_IDX) begin
      idx_s = MAX_IDX;
    end else begin
      idx_s = idx_r + IW'(1);
    end
    err_s = ((state_r == IDLE) && !in_first) || (idx_s >= MAX_IDX);
    ovf_s = in_last && (in_a[15] == b_s[15]) && (sum_s[15] != in_a[15]);
  end

  // Next-state logic: an accepted last word always closes the operation.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !in_last) state_next_s = BUSY;
        else                      state_next_s = IDLE;
      end
      BUSY: begin
        if (accept_s && in_last) state_next_s = IDLE;
        else                     state_next_s = BUSY;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Carry chain and output register; everything holds while the output stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_r   <= 1'b0;
      sub_r     <= 1'b0;
      idx_r     <= '0;
      out_valid <= 1'b0;
      out_s     <= 16'h0000;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept_s) begin
      carry_r   <= cout_s;
      sub_r     <= sub_s;
      idx_r     <= idx_s;
      out_valid <= 1'b1;
      out_s     <= sum_s;
      out_idx   <= idx_s;
      out_last  <= in_last;
      out_cout  <= cout_s;
      out_ovf   <= ovf_s;
      out_err   <= err_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Bench for multiword_adder_seq: directed test-plan vectors plus randomized traffic,
// all checked every cycle against an arithmetic reference model.

module tb_multiword_adder_seq;

  localparam int MAXW = 4;
  localparam int IW   = $clog2(MAXW) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_a;
  logic [15:0]   in_b;
  logic          in_first;
  logic          in_last;
  logic          in_sub;
  logic          in_cin;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_s;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_cout;
  logic          out_ovf;
  logic          out_err;

  multiword_adder_seq #(.MAX_WORDS(MAXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: operation context plus the expected output word.
  bit          m_busy  = 1'b0;
  bit          m_carry = 1'b0;
  bit          m_sub   = 1'b0;
  int          m_idx   = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_s     = 16'h0000;
  int          m_oidx  = 0;
  bit          m_last  = 1'b0;
  bit          m_cout  = 1'b0;
  bit          m_ovf   = 1'b0;
  bit          m_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_carry = 1'b0; m_sub = 1'b0; m_idx = 0;
    m_valid = 1'b0; m_s = 16'h0000; m_oidx = 0;
    m_last = 1'b0; m_cout = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
  endtask

  // One accepted beat computed with plain integer arithmetic.
  task automatic model_beat(input logic [15:0] a, input logic [15:0] b,
                            input bit f, input bit l, input bit s, input bit c);
    bit          first;
    bit          err;
    bit          se;
    int          ci;
    int          idx;
    int unsigned bb;
    int unsigned sum;
    int          sv;
    logic [15:0] bw;
    first = f || !m_busy;
    err   = !m_busy && !f;
    se    = first ? s : m_sub;
    ci    = first ? (s ? 1 : int'(c)) : int'(m_carry);
    idx   = first ? 0 : ((m_idx + 1 > MAXW) ? MAXW : m_idx + 1);
    if (idx >= MAXW) err = 1'b1;
    bb    = se ? (32'h0000FFFF - 32'(b)) : 32'(b);
    bw    = bb[15:0];
    sum   = 32'(a) + bb + 32'(ci);
    sv    = int'(shortint'(a)) + int'(shortint'(bw)) + ci;
    m_s     = sum[15:0];
    m_cout  = sum[16];
    m_carry = sum[16];
    m_ovf   = l && (sv > 32767 || sv < -32768);
    m_oidx  = idx;
    m_last  = l;
    m_err   = err;
    m_sub   = se;
    m_idx   = idx;
    m_busy  = !l;
    m_valid = 1'b1;
  endtask

  // Drive one cycle, advance the model at the edge, then check every output.
  task automatic step(input bit v, input logic [15:0] a, input logic [15:0] b,
                      input bit f, input bit l, input bit s, input bit c,
                      input bit r, input bit rs);
    bit acc;
    in_valid = v; in_a = a; in_b = b; in_first = f; in_last = l;
    in_sub = s; in_cin = c; out_ready = r; rst = rs;
    #1;
    if (!rs) chk("in_ready", 32'(in_ready), 32'(!m_valid || r));
    acc = v && (!m_valid || r) && !rs;
    @(posedge clk);
    if (rs)       model_reset();
    else if (acc) model_beat(a, b, f, l, s, c);
    else if (r)   m_valid = 1'b0;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid || rs) begin
      chk("out_s",    32'(out_s),    32'(m_s));
      chk("out_idx",  32'(out_idx),  32'(m_oidx));
      chk("out_last", 32'(out_last), 32'(m_last));
      chk("out_cout", 32'(out_cout), 32'(m_cout));
      chk("out_ovf",  32'(out_ovf),  32'(m_ovf));
      chk("out_err",  32'(out_err),  32'(m_err));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 16'h0000; in_b = 16'h0000;
    in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b1;

    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_rdy", 32'(in_ready), 32'd1);

    // Single-word add
    step(1'b1, 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sa_s", 32'(out_s), 32'h68AC);
    chk("sa_flags", {out_cout, out_ovf, out_last, out_err}, 32'b0010);
    chk("sa_idx", 32'(out_idx), 32'd0);

    // Two-word add with carry
    step(1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("tw0_s", 32'(out_s), 32'h0000);
    chk("tw0_cout", 32'(out_cout), 32'd1);
    step(1'b1, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("tw1_s", 32'(out_s), 32'h0002);
    chk("tw1_idx", {out_cout, out_last, 29'(out_idx)}, {1'b0, 1'b1, 29'd1});

    // Subtract overflow
    step(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("so_s", 32'(out_s), 32'h7FFF);
    chk("so_flags", {out_cout, out_ovf}, 32'b11);

    // Backpressure: next beat waits three stalled cycles, then chains the carry
    step(1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_hold", {out_valid, out_s}, {1'b1, 16'h0000});
    end
    step(1'b1, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_s", 32'(out_s), 32'h0002);
    chk("bp_idx", 32'(out_idx), 32'd1);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-operation
    step(1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rm_valid", 32'(out_valid), 32'd0);
    step(1'b1, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rm_s", 32'(out_s), 32'h0001);
    chk("rm_err", {out_err, 31'(out_idx)}, {1'b1, 31'd0});

    // Length overflow: five words without last, then a closing last word
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 16'h0000, 16'h0000, (k == 0), (k == 5), 1'b0, 1'b0, 1'b1, 1'b0);
      chk("lo_idx", 32'(out_idx), (k < MAXW) ? 32'(k) : 32'(MAXW));
      chk("lo_err", 32'(out_err), (k < MAXW) ? 32'd0 : 32'd1);
    end

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(3) != 0), 16'($urandom), 16'($urandom),
           ($urandom_range(3) == 0), ($urandom_range(2) == 0), 1'($urandom),
           1'($urandom), ($urandom_range(3) != 0), ($urandom_range(63) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
